// File: rtl/rv32_pkg.sv
// Shared RV32 front-end types and constants: bubble encoding, reset PC, fetch FSM states.
package rv32_pkg;

  localparam int          XLEN             = 32;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_ISSUE,
    ST_WAIT,
    ST_FULL,
    ST_DROP
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
  } ifid_t;

endpackage

// File: rtl/if_id_skid.sv
// One-entry holding register for a fetched instruction that arrived while ID was stalled.
// Latency: load visible next cycle. Flush wins over load; drain empties the entry.
module if_id_skid (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic          flush,
  input  logic          drain,
  input  rv32_pkg::ifid_t in_dat,
  output rv32_pkg::ifid_t out_dat,
  output logic          vld
);

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      vld <= 1'b0;
    end else if (load) begin
      vld     <= 1'b1;
      out_dat <= in_dat;
    end else if (drain) begin
      vld <= 1'b0;
    end
  end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch with IF/ID register: single outstanding imem request, one-entry skid
// while ID stalls, EX redirects flush IF/ID and discard any in-flight response.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC  = rv32_pkg::RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = rv32_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_rvalid,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] id_instruction,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4,
  output logic        id_valid
);
  import rv32_pkg::*;

  fetch_state_t state;
  logic [31:0]  pc;
  logic [31:0]  pc_plus4;
  logic [31:0]  redirect_pc;
  logic         accept;
  logic         to_id;
  logic         skid_load;
  logic         skid_drain;
  logic         skid_vld;
  ifid_t        skid_in;
  ifid_t        skid_out;

  assign pc_plus4    = pc + 32'd4;
  assign redirect_pc = {redirect_target[31:2], 2'b00};

  // A response is only ours in WAIT; anything seen in ISSUE/FULL is stale and ignored.
  assign accept     = (state == ST_WAIT) && imem_rvalid && !redirect_valid;
  assign to_id      = accept && (!stall || !id_valid);
  assign skid_load  = accept && stall && id_valid;
  assign skid_drain = (state == ST_FULL) && !stall && !redirect_valid;
  assign skid_in    = '{instr: imem_rdata, pc: pc, pc_plus4: pc_plus4};

  assign imem_req  = (state == ST_ISSUE) && !redirect_valid && !reset;
  assign imem_addr = pc;

  if_id_skid u_skid (
    .clk     (clk),
    .reset   (reset),
    .load    (skid_load),
    .flush   (redirect_valid),
    .drain   (skid_drain),
    .in_dat  (skid_in),
    .out_dat (skid_out),
    .vld     (skid_vld)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_ISSUE;
      pc             <= RESET_PC;
      id_valid       <= 1'b0;
      id_instruction <= NOP_INSTR;
      id_pc          <= 32'h0000_0000;
      id_pc_plus4    <= 32'h0000_0004;
    end else begin
      if (redirect_valid) begin
        id_valid       <= 1'b0;
        id_instruction <= NOP_INSTR;
      end else if (to_id) begin
        id_valid       <= 1'b1;
        id_instruction <= imem_rdata;
        id_pc          <= pc;
        id_pc_plus4    <= pc_plus4;
      end else if (skid_drain && skid_vld) begin
        id_valid       <= 1'b1;
        id_instruction <= skid_out.instr;
        id_pc          <= skid_out.pc;
        id_pc_plus4    <= skid_out.pc_plus4;
      end else if (!stall) begin
        id_valid       <= 1'b0;
        id_instruction <= NOP_INSTR;
      end

      if (redirect_valid) begin
        pc <= redirect_pc;
        // An outstanding request stays owed unless its response lands this very cycle.
        case (state)
          ST_WAIT, ST_DROP: state <= imem_rvalid ? ST_ISSUE : ST_DROP;
          default:          state <= ST_ISSUE;
        endcase
      end else begin
        case (state)
          ST_ISSUE: state <= ST_WAIT;
          ST_WAIT: begin
            if (imem_rvalid) begin
              pc    <= pc_plus4;
              state <= to_id ? ST_ISSUE : ST_FULL;
            end
          end
          ST_FULL: if (!stall) state <= ST_ISSUE;
          ST_DROP: if (imem_rvalid) state <= ST_ISSUE;
          default: state <= ST_ISSUE;
        endcase
      end
    end
  end

endmodule
